instruction_fetch: RTL

Fetch stage of the pipelined RV32I core. It owns the program counter and issues word requests to instruction memory. Returned words are buffered in a 2-entry fetch queue, and the queue head is presented to decode as `if_instruction`, which feeds the instruction field parser directly. It also handles decode backpressure (`stall`) and control-flow redirects from execute.

---
 rtl/instruction_fetch_if.sv | 26 ++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). The response is expected one cycle after
// an accepted request.
interface instruction_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the RV32I pipeline. Owns the program counter, issues
// word requests to instruction memory and buffers returned words in a
// 2-entry queue whose head is presented to decode. Requests are throttled
// so the single in-flight response always has a free queue slot.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_if.master        imem,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       stall,
  output logic                       if_valid,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_pc_plus4,
  output logic [31:0]                if_instruction
);

  logic [31:0] pc_r;
  logic [31:0] req_pc_r;
  logic        inflight_r;
  logic [31:0] q_pc_r   [2];
  logic [31:0] q_insn_r [2];
  logic [1:0]  count_r;

  logic        if_valid_s;
  logic        pop_s;
  logic        push_s;
  logic        req_valid_s;
  logic        accept_s;
  logic [2:0]  occupancy_s;

  // Handshake decode: pop/push strobes and the projected-occupancy request gate.
  always_comb begin
    if_valid_s  = (count_r != 2'd0) && !rst;
    pop_s       = if_valid_s && !stall;
    // Slots that will be occupied once the in-flight word lands and this
    // cycle's pop retires; a new request needs one more free slot.
    occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    req_valid_s = !rst && !redirect_valid && (occupancy_s < 3'd2);
    accept_s    = req_valid_s && imem.req_ready;
    // A response without a matching accepted request is ignored; redirect drops it.
    push_s      = inflight_r && imem.resp_valid && !redirect_valid;
  end

  // PC, in-flight tracking and the 2-entry fetch queue (head at index 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      req_pc_r    <= 32'h0000_0000;
      inflight_r  <= 1'b0;
      count_r     <= 2'd0;
      q_pc_r[0]   <= 32'h0000_0000;
      q_pc_r[1]   <= 32'h0000_0000;
      q_insn_r[0] <= 32'h0000_0000;
      q_insn_r[1] <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_r       <= redirect_pc & 32'hFFFF_FFFC;
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (accept_s) begin
        pc_r       <= pc_r + 32'd4;
        req_pc_r   <= pc_r;
        inflight_r <= 1'b1;
      end else begin
        inflight_r <= 1'b0;
      end

      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            q_pc_r[0]   <= req_pc_r;
            q_insn_r[0] <= imem.resp_data;
            count_r     <= 2'd1;
          end else if (count_r == 2'd1) begin
            q_pc_r[1]   <= req_pc_r;
            q_insn_r[1] <= imem.resp_data;
            count_r     <= 2'd2;
          end else begin
            count_r     <= count_r;
          end
        end
        2'b01: begin
          q_pc_r[0]   <= q_pc_r[1];
          q_insn_r[0] <= q_insn_r[1];
          count_r     <= count_r - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: count is unchanged, order preserved.
          if (count_r == 2'd1) begin
            q_pc_r[0]   <= req_pc_r;
            q_insn_r[0] <= imem.resp_data;
          end else begin
            q_pc_r[0]   <= q_pc_r[1];
            q_insn_r[0] <= q_insn_r[1];
            q_pc_r[1]   <= req_pc_r;
            q_insn_r[1] <= imem.resp_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Drive the memory request and the decode-facing head of the queue.
  always_comb begin
    imem.req_valid = req_valid_s;
    imem.req_addr  = pc_r;
    if_valid       = if_valid_s;
    if (rst) begin
      if_pc = 32'h0000_0000;
    end else begin
      if_pc = q_pc_r[0];
    end
    if_pc_plus4 = if_pc + 32'd4;
    if (if_valid_s) begin
      if_instruction = q_insn_r[0];
    end else begin
      if_instruction = NOP_INSN;
    end
  end

endmodule
